uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receive deserializer that sits directly downstream of the baud tick generator.
- Consumes the generator's one-clk-wide 16x-oversampling tick (s_tick), synchronizes the asynchronous rx line, and recovers start/data/stop framing.
- Presents each received word on dout with a one-cycle rx_done_tick strobe and a frame error flag.
- Targets 8N1 by default; data width and stop length are parameterized.

Parameters:
- DBIT, 8, number of data bits per frame, legal range 5..8, sent LSB first.
- SB_TICK, 16, stop-bit length in s_ticks: 16 = 1 stop bit, 24 = 1.5, 32 = 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset; asserting 0 resets immediately, release is used synchronously.
- rx  input  1  serial line, asynchronous to clk, idle high.
- s_tick  input  1  oversampling tick from the baud generator, one clk wide, 16 per bit period.
- dout  output  DBIT  last received data word.
- rx_done_tick  output  1  one-clk pulse: dout and frame_err updated.
- frame_err  output  1  stop-bit sample of last frame was 0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0):
  - state=IDLE; dout=0, rx_done_tick=0, frame_err=0, busy=0.
  - Both rx synchronizer flops = 1.
  - Tick counter s=0, bit counter n=0, shift register b=0.
- Synchronizer: rx passes through a 2-flop synchronizer; all decisions use the synchronized value rx_s (2 clk latency).
- Counters: s is 6 bits, n is 3 bits. s counts s_ticks only and never wraps past its compare value.
- FSM states: IDLE, START, DATA, STOP. All transitions happen on clk edges.
- IDLE:
  - rx_s==0 -> START with s=0. No tick is required for this transition.
  - s_tick is ignored in IDLE.
- START, on s_tick:
  - if s==7 and rx_s==0 -> DATA, s=0, n=0 (mid-start-bit confirm).
  - if s==7 and rx_s==1 -> IDLE (glitch rejected, no outputs change).
  - otherwise s=s+1.
- DATA, on s_tick:
  - if s==15: s=0 and b={rx_s, b[DBIT-1:1]}, so samples land at the mid-bit of each data bit. If n==DBIT-1 -> STOP, else n=n+1.
  - otherwise s=s+1.
- STOP, on s_tick:
  - if s==SB_TICK-1 -> IDLE, dout=b, frame_err=~rx_s, rx_done_tick=1.
  - otherwise s=s+1.
  - A frame error still delivers dout; there is no resynchronization hunt.
- Clock cycles without s_tick hold all state and counters.
- rx_done_tick:
  - Registered; high for exactly one clk, in the cycle after the edge that completes STOP.
  - Never high on two consecutive clks.
- dout and frame_err hold their values until the next rx_done_tick.
- busy = (state != IDLE), registered with the state.
- Back-to-back frames:
  - After STOP the FSM is in IDLE.
  - A start bit already low at that point is detected on the next clk, with no idle bit required.
  - Start alignment error is at most 1 tick.
- Line held low (break):
  - Produces a frame with dout=0 and frame_err=1.
  - The FSM then re-enters START while rx stays low.
- Reset mid-frame: the rx_done_tick of the aborted frame is never issued. The next complete frame after reset release is received normally.
- rx toggling between ticks: only the rx_s value on tick cycles matters in START, DATA and STOP.

Test Plan:
- Bench drives s_tick every 4 clk (bit period 64 clk).
  - Send 8N1 frame 0xA5 -> exactly one rx_done_tick.
  - At that strobe: dout=0xA5, frame_err=0, busy=0 one clk later.
- rx low for 3 ticks then high (glitch) -> FSM returns to IDLE after tick 8; no rx_done_tick; dout unchanged.
- Frame 0x00 with stop bit driven 0 -> rx_done_tick with dout=0x00, frame_err=1.
  - A following good frame 0x7E then clears frame_err to 0.
- Back-to-back frames 0x01 and 0xFE with no idle gap -> two rx_done_tick pulses about 640 clk apart, dout 0x01 then 0xFE, frame_err=0 both.
- Assert rst low during data bit 4 of 0x3C:
  - All outputs go to reset values immediately; no strobe is issued for the aborted frame.
  - After release, a new frame 0xC3 -> dout=0xC3.
- Parameter variant DBIT=7, SB_TICK=32: send 0x55 with 2 stop bits.
  - rx_done_tick arrives 32 ticks after the last data-bit sample; dout=7'h55, frame_err=0.

Source files
------------

// File: rtl/uart_rx.sv
// UART receive deserializer driven by a 16x oversampling tick.
// Recovers start/data/stop framing from a 2-flop synchronized rx line.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [5:0] START_MID = 6'd7;
  localparam logic [5:0] BIT_LAST  = 6'd15;
  localparam logic [5:0] STOP_LAST = 6'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  state_t          state;
  logic            rx_meta;
  logic            rx_s;
  logic [5:0]      s;
  logic [2:0]      n;
  logic [DBIT-1:0] b;

  // Synchronizer resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == START_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                // Start bit did not survive to mid-bit: treat as a glitch.
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              s <= s + 6'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == BIT_LAST) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              if (n == N_LAST) state <= STOP;
              else             n     <= n + 3'd1;
            end else begin
              s <= s + 6'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == STOP_LAST) begin
              state        <= IDLE;
              busy         <= 1'b0;
              dout         <= b;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
            end else begin
              s <= s + 6'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: 8N1 instance plus a DBIT=7, 2-stop-bit instance.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rx7;
  logic       s_tick;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       busy;
  logic [6:0] dout7;
  logic       rx_done_tick7;
  logic       frame_err7;
  logic       busy7;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t_start  = 0;
  int done_cnt = 0;
  int done_cnt7 = 0;
  int last_done_cyc = 0;
  int last_done_cyc7 = 0;
  logic prev_done  = 1'b0;
  logic prev_done7 = 1'b0;

  logic [8:0] exp_q[$];
  logic [7:0] exp_q7[$];

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .s_tick(s_tick),
    .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err), .busy(busy)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (
    .clk(clk), .rst(rst), .rx(rx7), .s_tick(s_tick),
    .dout(dout7), .rx_done_tick(rx_done_tick7), .frame_err(frame_err7), .busy(busy7)
  );

  // Clock and tick generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    int k;
    k = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      s_tick = (k == 3);
      k = (k + 1) % 4;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Driver tasks
  task automatic drive_line(input bit sel, input logic v);
    if (sel) rx7 = v;
    else     rx  = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] data, input int nbits,
                            input int stop_clk, input bit bad_stop);
    @(posedge clk);
    #1;
    t_start = cyc;
    drive_line(sel, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      repeat (64) @(posedge clk);
      #1;
      drive_line(sel, data[i]);
    end
    repeat (64) @(posedge clk);
    #1;
    if (bad_stop) begin
      drive_line(sel, 1'b0);
      repeat (48) @(posedge clk);
      #1;
      drive_line(sel, 1'b1);
      repeat (stop_clk - 49) @(posedge clk);
    end else begin
      drive_line(sel, 1'b1);
      repeat (stop_clk - 1) @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboards
  always @(negedge clk) begin
    logic [8:0] e;
    if (rx_done_tick) begin
      done_cnt++;
      last_done_cyc = cyc;
      check("done_gap", prev_done, 0);
      check("busy_at_done", busy, 0);
      check("queue_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dout", dout, e[7:0]);
        check("frame_err", frame_err, e[8]);
      end
    end
    prev_done = rx_done_tick;
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (rx_done_tick7) begin
      done_cnt7++;
      last_done_cyc7 = cyc;
      check("done_gap7", prev_done7, 0);
      check("queue7_nonempty", exp_q7.size() != 0, 1);
      if (exp_q7.size() != 0) begin
        e = exp_q7.pop_front();
        check("dout7", dout7, e[6:0]);
        check("frame_err7", frame_err7, e[7]);
      end
    end
    prev_done7 = rx_done_tick7;
  end

  initial begin
    int lat;
    int cnt_before;
    rst = 1'b0;
    rx  = 1'b1;
    rx7 = 1'b1;
    idle(5);
    check("rst_dout", dout, 0);
    check("rst_done", rx_done_tick, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    idle(50);

    // Basic 8N1 frame with start-to-strobe latency
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(1'b0, 8'hA5, 8, 64, 1'b0);
    lat = last_done_cyc - t_start;
    check("lat_a5_in_606_613", (lat >= 606 && lat <= 613), 1);
    check("count_a5", done_cnt, 1);
    idle(100);

    // Glitch of three ticks must be rejected
    cnt_before = done_cnt;
    rx = 1'b0;
    idle(12);
    rx = 1'b1;
    idle(8);
    check("glitch_busy", busy, 1);
    idle(100);
    check("glitch_idle", busy, 0);
    check("glitch_no_done", done_cnt, cnt_before);
    check("glitch_dout", dout, 8'hA5);

    // Bad stop bit, then a good frame clears the error
    exp_q.push_back({1'b1, 8'h00});
    send_frame(1'b0, 8'h00, 8, 64, 1'b1);
    idle(100);
    check("after_bad_stop_idle", busy, 0);
    exp_q.push_back({1'b0, 8'h7E});
    send_frame(1'b0, 8'h7E, 8, 64, 1'b0);
    idle(100);

    // Back-to-back frames without idle gap
    cnt_before = done_cnt;
    exp_q.push_back({1'b0, 8'h01});
    send_frame(1'b0, 8'h01, 8, 64, 1'b0);
    lat = last_done_cyc;
    exp_q.push_back({1'b0, 8'hFE});
    send_frame(1'b0, 8'hFE, 8, 64, 1'b0);
    lat = last_done_cyc - lat;
    check("b2b_count", done_cnt - cnt_before, 2);
    check("b2b_spacing_636_644", (lat >= 636 && lat <= 644), 1);
    idle(100);

    // Reset during data bit 4 of 0x3C
    cnt_before = done_cnt;
    @(posedge clk);
    #1;
    rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (64) @(posedge clk);
      #1;
      rx = (8'h3C >> i) & 1;
    end
    repeat (64) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (32) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_dout", dout, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", rx_done_tick, 0);
    idle(10);
    rst = 1'b1;
    idle(700);
    check("midrst_no_done", done_cnt, cnt_before);
    exp_q.push_back({1'b0, 8'hC3});
    send_frame(1'b0, 8'hC3, 8, 64, 1'b0);
    idle(100);

    // Variant instance: 7 data bits, two stop bits
    exp_q7.push_back({1'b0, 8'h55});
    send_frame(1'b1, 8'h55, 7, 128, 1'b0);
    lat = last_done_cyc7 - t_start;
    check("lat7_in_606_613", (lat >= 606 && lat <= 613), 1);
    idle(100);

    check("total_done", done_cnt, 6);
    check("total_done7", done_cnt7, 1);
    check("queue_drained", exp_q.size(), 0);
    check("queue7_drained", exp_q7.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
